// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the add/sub unit arbiter and its rotating-priority picker.
package add_arb_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAX_REQ   = 4;
  localparam int unsigned IDX_MAX_W = 2;

  typedef enum logic [1:0] {IDLE, START, WAIT_FIN, RELEASE} arb_state_t;

  typedef struct packed {
    logic              sub;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
  } add_op_t;

  // Index of the first set req after 'last' (with wrap) among n requesters; 'last' if none.
  function automatic logic [IDX_MAX_W-1:0] rr_next(input logic [MAX_REQ-1:0]   req,
                                                   input logic [IDX_MAX_W-1:0] last,
                                                   input int unsigned          n);
    logic [IDX_MAX_W-1:0] pick;
    int                   cand;
    pick = last;
    // Walk from the farthest offset back so the nearest candidate after 'last' overwrites.
    for (int i = int'(MAX_REQ); i > 0; i--) begin
      if (i <= int'(n)) begin
        cand = (int'(last) + i) % int'(n);
        if (req[IDX_MAX_W'(cand)]) pick = IDX_MAX_W'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set req after last_grant, with wrap.
module rr_pick
  import add_arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [MAX_REQ-1:0]   req_ext;
  logic [IDX_MAX_W-1:0] pick;

  always_comb begin
    req_ext = MAX_REQ'(req);
    pick    = rr_next(req_ext, IDX_MAX_W'(last), N);
  end

  assign valid_c = |req;
  assign idx_c   = IDX_W'(pick);

endmodule

// File: rtl/add_arbiter.sv
// Round-robin share of one sign-magnitude add/sub unit among NUM_REQ requesters.
// Define ADD_ARB_TIMEOUT_EN to add a finish watchdog with a sticky err flag.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DATA_W*NUM_REQ-1:0] req_in1,
  input  logic [DATA_W*NUM_REQ-1:0] req_in2,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         result,
  output logic                      busy,
  output logic                      err,
  output logic                      add_start,
  output logic                      add_sub,
  output logic [DATA_W-1:0]         add_in1,
  output logic [DATA_W-1:0]         add_in2,
  input  logic [DATA_W-1:0]         add_out,
  input  logic                      add_finish
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  add_op_t             op_q, op_d;
  logic                add_start_q, add_start_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                timeout_c;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

`ifdef ADD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cleared on entry to START/RELEASE, advancing while waiting on the unit.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == START) || ((state_d == RELEASE) && (state_q != RELEASE))) begin
      cnt_d = '0;
    end else if ((state_q == WAIT_FIN) || (state_q == RELEASE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    op_d        = op_q;
    add_start_d = add_start_q;
    result_d    = result_q;
    done_d      = '0;
`ifdef ADD_ARB_TIMEOUT_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d       = pick_idx;
          op_d.in1    = req_in1[DATA_W*int'(pick_idx) +: DATA_W];
          op_d.in2    = req_in2[DATA_W*int'(pick_idx) +: DATA_W];
          op_d.sub    = req_sub[pick_idx];
          add_start_d = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        state_d = WAIT_FIN;
      end
      WAIT_FIN: begin
        if (add_finish) begin
          result_d    = add_out;
          add_start_d = 1'b0;
          state_d     = RELEASE;
        end else if (timeout_c) begin
          result_d    = '0;
          add_start_d = 1'b0;
          state_d     = RELEASE;
`ifdef ADD_ARB_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end
      end
      RELEASE: begin
        // start stays low until the unit has dropped finish, so it is never re-raised early.
        if (!add_finish || timeout_c) begin
`ifdef ADD_ARB_TIMEOUT_EN
          if (add_finish) begin
            result_d = '0;
            err_d    = 1'b1;
          end
`endif
          done_d[gnt_q] = 1'b1;
          last_d        = gnt_q;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      op_q        <= '0;
      add_start_q <= 1'b0;
      result_q    <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      op_q        <= op_d;
      add_start_q <= add_start_d;
      result_q    <= result_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign add_start = add_start_q;
  assign add_sub   = op_q.sub;
  assign add_in1   = op_q.in1;
  assign add_in2   = op_q.in2;

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Round-robin scheduler that shares one 16-bit sign-magnitude add/sub unit between NUM_REQ requesters (keypad path, memory/recall path, ...).
- Latches the winning requester's operands and operation, runs the unit's start/finish handshake to completion, and returns the result with a one-cycle done pulse.
- Sits between the calculator front-end sources and the single add/sub datapath instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 15, watchdog limit in cycles; used only with ADD_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level
- req_in1  input  16*NUM_REQ  operand A per requester, slice i = [16i+15:16i], sign-magnitude
- req_in2  input  16*NUM_REQ  operand B per requester, sign-magnitude
- req_sub  input  NUM_REQ  1 = subtract, 0 = add
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester
- result  output  16  sign-magnitude result, valid while done is nonzero and held until the next completion
- busy  output  1  high whenever not in IDLE
- err  output  1  timeout flag, 0 unless ADD_ARB_TIMEOUT_EN
- add_start  output  1  to unit start
- add_sub  output  1  to unit sub
- add_in1  output  16  to unit operand A
- add_in2  output  16  to unit operand B
- add_out  input  16  from unit result
- add_finish  input  1  from unit finish

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- The unit's contract: it samples operands and sub in the cycle after start rises; finish rises a few cycles later and stays high while start stays high. After start falls, finish returns to 0 within 2 cycles. The arbiter must not raise start again until finish reads 0.
- State IDLE:
  - If any req is high, select the first requester with req high, searching from last_grant+1 upward with wrap.
  - Register gnt; latch that requester's in1, in2 and sub into add_in1, add_in2 and add_sub; go to START.
- State START: add_start = 1; go to WAIT_FIN.
- State WAIT_FIN:
  - Hold add_start = 1 and keep the latched operands stable.
  - On add_finish = 1, capture add_out into result, drop add_start, and go to RELEASE.
- State RELEASE:
  - add_start = 0; wait until add_finish = 0.
  - Then pulse done[gnt] for exactly 1 cycle, set last_grant = gnt, and go to IDLE.
- Latency: done asserts one cycle after add_finish falls.
- Operands are latched, so requester inputs may change after grant without affecting the operation.
- A req that drops after grant does not cancel the operation; the done pulse is still issued.
- A requester holding req high after its done is treated as a new request, but loses to any other pending requester on the next arbitration (fairness).
- Requests that arrive in the same cycle are resolved purely by the rotating pointer.
- Requests arriving while busy wait; they are not lost as long as req stays high.
- Reset mid-operation: the arbiter returns to IDLE immediately, and add_start = 0 within the reset cycle. The unit shares the same nRST.
- busy = (state != IDLE).

Optional Feature:
- Macro: ADD_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to START or RELEASE and counts while in WAIT_FIN or RELEASE.
  - Reaching TIMEOUT_CYCLES forces add_start = 0, sets result = 16'h0000, and pulses done[gnt].
  - err is set sticky until reset, and the block returns to IDLE through RELEASE.
- Without the macro: no counter, err tied to 0, and the block waits indefinitely.

Decomposition:
- Package add_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, START, WAIT_FIN, RELEASE};
  - constant DATA_W = 16;
  - function rr_next(req, last) returning a grant index.
- One sub-module, rr_pick: a combinational rotating-priority encoder (req vector, last_grant) -> (valid, index). It is reused by later shared-resource arbiters.

Test Plan:
- req = 01, in1 = 0x0005, in2 = 0x0003, sub = 0 -> add_start held until finish; done = 01 once; result = 0x0008; add_start never re-rises before finish = 0.
- req = 11 in the same cycle after reset, r0: 0x0002 - 0x0007, r1: 0x8004 + 0x0001 -> r0 served first with result 0x8005, then r1 with result 0x8003.
- r0 holds req continuously while r1 requests -> grants alternate 0, 1, 0, 1; neither is starved.
- Change req_in1 and req_sub of the granted requester during WAIT_FIN -> result reflects the latched values.
- Pull nRST low during WAIT_FIN -> all outputs 0 immediately; after release, a fresh req = 10 is served normally.
- ADD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 15, add_finish stuck at 0 -> done pulses at cycle 15 after START with result 0x0000; err = 1 and stays 1.
